// File: rtl/frame_seq_if.sv
// Byte/strobe bus between frame_seq and the uart_rx, uart_tx and net_proc blocks.
interface frame_seq_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       mem_rst;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic       net_start;
  logic       net_done;
  logic [3:0] net_result;
  logic       tx_rq;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       busy;
  logic       frame_err;
  logic [3:0] last_result;

  modport master (
    input  rx_ready, rx_data, net_done, net_result, tx_busy,
    output mem_rst, mem_we, mem_wdata, net_start, tx_rq, tx_data,
           busy, frame_err, last_result
  );

  modport slave (
    output rx_ready, rx_data, net_done, net_result, tx_busy,
    input  mem_rst, mem_we, mem_wdata, net_start, tx_rq, tx_data,
           busy, frame_err, last_result
  );
endinterface

// File: rtl/frame_seq.sv
// Frame sequencer: gathers FRAME_LEN rx bytes into net_proc memory, starts inference, sends ASCII result (FRAME_SEQ_TIMEOUT_EN adds RECV idle abort).
// Latency: byte strobe -> mem_we 2 cycles, last byte -> net_start 3 cycles, done edge -> tx_rq 2 cycles minimum.
// Backpressure: tx_rq is held off while tx_busy is high; bytes arriving outside IDLE/RECV are dropped and flagged.
module frame_seq #(
  parameter int unsigned FRAME_LEN   = 784,
  parameter int unsigned CNT_W       = 10,
`ifdef FRAME_SEQ_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
`endif
  parameter logic [7:0]  ASCII_BASE  = 8'h30
) (
  input  logic        clk,
  input  logic        nRST,
  frame_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, RECV, START, WAIT, SEND} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rx_ready_q, net_done_q;
  logic             pend_q, pend_d;
  logic [7:0]       pend_dat_q, pend_dat_d;
  logic             mem_rst_q, mem_rst_d;
  logic             mem_we_q, mem_we_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             net_start_q, net_start_d;
  logic             tx_rq_q, tx_rq_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic [3:0]       last_result_q, last_result_d;
  logic             stb, dne;

  assign stb = bus.rx_ready && !rx_ready_q;
  assign dne = bus.net_done && !net_done_q;

`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYC - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    pend_d        = 1'b0;
    pend_dat_d    = pend_dat_q;
    mem_rst_d     = 1'b0;
    // Accepted bytes sit in a one-deep stage so mem_rst always precedes the first write.
    mem_we_d      = pend_q;
    mem_wdata_d   = pend_q ? pend_dat_q : mem_wdata_q;
    net_start_d   = 1'b0;
    tx_rq_d       = 1'b0;
    tx_data_d     = tx_data_q;
    frame_err_d   = frame_err_q;
    last_result_d = last_result_q;
`ifdef FRAME_SEQ_TIMEOUT_EN
    idle_d        = '0;
`endif

    case (state_q)
      IDLE: begin
        if (stb) begin
          mem_rst_d  = 1'b1;
          pend_d     = 1'b1;
          pend_dat_d = bus.rx_data;
          count_d    = CNT_W'(1);
          state_d    = RECV;
        end
      end
      RECV: begin
        if (count_q == LAST_CNT) begin
          state_d = START;
          if (stb) frame_err_d = 1'b1;
        end else if (stb) begin
          pend_d     = 1'b1;
          pend_dat_d = bus.rx_data;
          count_d    = count_q + 1'b1;
        end
`ifdef FRAME_SEQ_TIMEOUT_EN
        else if (idle_q == IDLE_LIM) begin
          frame_err_d = 1'b1;
          count_d     = '0;
          state_d     = IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
`endif
      end
      START: begin
        net_start_d = 1'b1;
        state_d     = WAIT;
        if (stb) frame_err_d = 1'b1;
      end
      WAIT: begin
        if (stb) frame_err_d = 1'b1;
        if (dne) begin
          last_result_d = bus.net_result;
          tx_data_d     = ASCII_BASE + {4'h0, bus.net_result};
          state_d       = SEND;
        end
      end
      SEND: begin
        if (stb) frame_err_d = 1'b1;
        if (!bus.tx_busy) begin
          tx_rq_d = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      count_q       <= '0;
      rx_ready_q    <= 1'b0;
      net_done_q    <= 1'b0;
      pend_q        <= 1'b0;
      pend_dat_q    <= '0;
      mem_rst_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      net_start_q   <= 1'b0;
      tx_rq_q       <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      last_result_q <= 4'hF;
`ifdef FRAME_SEQ_TIMEOUT_EN
      idle_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rx_ready_q    <= bus.rx_ready;
      net_done_q    <= bus.net_done;
      pend_q        <= pend_d;
      pend_dat_q    <= pend_dat_d;
      mem_rst_q     <= mem_rst_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      net_start_q   <= net_start_d;
      tx_rq_q       <= tx_rq_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      frame_err_q   <= frame_err_d;
      last_result_q <= last_result_d;
`ifdef FRAME_SEQ_TIMEOUT_EN
      idle_q        <= idle_d;
`endif
    end
  end

  assign bus.mem_rst     = mem_rst_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.net_start   = net_start_q;
  assign bus.tx_rq       = tx_rq_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = busy_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.last_result = last_result_q;

endmodule

// File: tb/tb_frame_seq.sv
// Bench for frame_seq: per-frame vector table plus hand sequences for reset abort and idle timeout.
module tb_frame_seq;
  localparam int FRAME_LEN = 784;

  typedef struct {
    logic [7:0] seed;
    logic [3:0] res;
    int         busy_cyc;
    bit         extra;
    logic [7:0] exp_tx;
  } vec_t;

  logic clk  = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  frame_seq_if bus();

  frame_seq #(
    .FRAME_LEN(FRAME_LEN),
    .CNT_W(10),
`ifdef FRAME_SEQ_TIMEOUT_EN
    .TIMEOUT_CYC(100),
`endif
    .ASCII_BASE(8'h30)
  ) dut (
    .clk(clk),
    .nRST(nRST),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rst_cnt = 0, rst_cyc = -1;
  int we_cnt = 0, first_we_cyc = -1;
  int start_cnt = 0, start_cyc = -1;
  int tx_cnt = 0, tx_cyc = -1;
  logic [7:0] exp_q[$];
  logic err_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every write must match the oldest accepted byte.
  always @(negedge clk) begin
    if (bus.mem_rst === 1'b1) begin
      rst_cnt++;
      rst_cyc = cyc;
    end
    if (bus.mem_we === 1'b1) begin
      if (we_cnt == 0) first_we_cyc = cyc;
      we_cnt++;
      chk("we_has_expectation", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("mem_wdata", bus.mem_wdata, exp_q.pop_front());
    end
    if (bus.net_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (bus.tx_rq === 1'b1) begin
      tx_cnt++;
      tx_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    rst_cnt = 0;
    we_cnt = 0;
    start_cnt = 0;
    tx_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push, output int t);
    tick();
    bus.rx_ready = 1'b1;
    bus.rx_data = b;
    t = cyc;
    if (push) exp_q.push_back(b);
    tick();
    bus.rx_ready = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_mem_rst", bus.mem_rst, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_net_start", bus.net_start, 0);
    chk("rst_tx_rq", bus.tx_rq, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_last_result", bus.last_result, 4'hF);
  endtask

  task automatic run_vector(input vec_t v, input bit pre);
    int t_last, t_x, d, b, want;
    t_last = -1;
    for (int i = (pre ? 1 : 0); i < FRAME_LEN; i++) send_byte(8'(i + int'(v.seed)), 1'b1, t_last);
    repeat (6) tick();
    chk("mem_rst_count", rst_cnt, 1);
    chk("first_we_after_rst", first_we_cyc, rst_cyc + 1);
    chk("we_count", we_cnt, FRAME_LEN);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("net_start_count", start_cnt, 1);
    chk("net_start_cycle", start_cyc, t_last + 3);
    chk("busy_in_wait", bus.busy, 1);
    chk("frame_err_after_frame", bus.frame_err, err_exp);
    if (v.extra) begin
      send_byte(8'hEE, 1'b0, t_x);
      err_exp = 1'b1;
      repeat (3) tick();
      chk("extra_byte_dropped", we_cnt, FRAME_LEN);
      chk("frame_err_extra", bus.frame_err, 1);
    end
    bus.tx_busy = (v.busy_cyc > 0);
    tick();
    bus.net_result = v.res;
    bus.net_done = 1'b1;
    d = cyc;
    for (int k = 0; k < v.busy_cyc; k++) tick();
    chk("no_rq_while_busy", tx_cnt, 0);
    bus.tx_busy = 1'b0;
    b = cyc;
    want = (b + 1 > d + 2) ? b + 1 : d + 2;
    repeat (6) tick();
    chk("tx_rq_count", tx_cnt, 1);
    chk("tx_rq_cycle", tx_cyc, want);
    chk("tx_data", bus.tx_data, v.exp_tx);
    chk("last_result", bus.last_result, v.res);
    chk("busy_after_send", bus.busy, 0);
    chk("frame_err_end", bus.frame_err, err_exp);
    bus.net_done = 1'b0;
    repeat (3) tick();
    chk("tx_rq_single", tx_cnt, 1);
  endtask

  vec_t vecs[4];
  vec_t rv;
  int t_dummy;

  initial begin
    vecs[0] = '{seed: 8'h00, res: 4'd7,  busy_cyc: 0,  extra: 1'b0, exp_tx: 8'h37};
    vecs[1] = '{seed: 8'h55, res: 4'hF,  busy_cyc: 50, extra: 1'b0, exp_tx: 8'h3F};
    vecs[2] = '{seed: 8'hA0, res: 4'd0,  busy_cyc: 0,  extra: 1'b1, exp_tx: 8'h30};
    vecs[3] = '{seed: 8'h11, res: 4'd9,  busy_cyc: 3,  extra: 1'b0, exp_tx: 8'h39};

    bus.rx_ready = 1'b0;
    bus.rx_data = 8'h00;
    bus.net_done = 1'b0;
    bus.net_result = 4'h0;
    bus.tx_busy = 1'b0;

    repeat (3) tick();
    check_reset_vals();
    nRST = 1'b1;
    repeat (2) tick();
    chk("idle_busy", bus.busy, 0);

    for (int n = 0; n < 4; n++) begin
      begin_frame();
      run_vector(vecs[n], 1'b0);
    end

    // Reset mid-frame, then a byte already pending as reset releases is byte 0.
    begin_frame();
    for (int i = 0; i < 500; i++) send_byte(8'(i), 1'b1, t_dummy);
    repeat (3) tick();
    chk("partial_we", we_cnt, 500);
    nRST = 1'b0;
    #1;
    check_reset_vals();
    err_exp = 1'b0;
    rv = '{seed: 8'h3C, res: 4'd5, busy_cyc: 0, extra: 1'b0, exp_tx: 8'h35};
    tick();
    begin_frame();
    bus.rx_ready = 1'b1;
    bus.rx_data = rv.seed;
    exp_q.push_back(rv.seed);
    tick();
    nRST = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    run_vector(rv, 1'b1);

`ifdef FRAME_SEQ_TIMEOUT_EN
    begin_frame();
    for (int i = 0; i < 300; i++) send_byte(8'(i + 3), 1'b1, t_dummy);
    repeat (110) tick();
    chk("timeout_frame_err", bus.frame_err, 1);
    chk("timeout_idle", bus.busy, 0);
    chk("timeout_we", we_cnt, 300);
    chk("timeout_no_start", start_cnt, 0);
    err_exp = 1'b1;
    begin_frame();
    rv = '{seed: 8'h77, res: 4'd2, busy_cyc: 0, extra: 1'b0, exp_tx: 8'h32};
    run_vector(rv, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
